muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Multicycle multiply/divide/modulo unit for the SimpleRISC execute stage.
- Time-shares one WIDTH-bit adder/subtractor over WIDTH iterations: shift-add for mul, restoring division for div/mod.
- The core pipeline issues a start pulse, stalls on busy, and collects the result on done.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request pulse; sampled only when state is IDLE or DONE
- op  input  2  00 mul (low WIDTH bits of product), 01 div (quotient), 10 mod (remainder), 11 reserved (behaves as mul)
- a  input  WIDTH  multiplicand / dividend
- b  input  WIDTH  multiplier / divisor
- busy  output  1  high while iterating
- done  output  1  single-cycle completion strobe
- result  output  WIDTH  result; held stable until the next accepted start
- div_by_zero  output  1  flag for the last completed op; valid with done, held with result

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy=0, done=0, result=0, div_by_zero=0; iteration counter and internal registers cleared. An in-flight operation is abandoned; no done is issued for it.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on start.
  - RUN -> DONE when the counter reaches WIDTH-1 iteration complete.
  - DONE -> RUN on start (back-to-back ops allowed); otherwise DONE -> IDLE.
- Accept (start in IDLE/DONE): latch a, b, op; counter=0; busy=1 from the next cycle.
- start while busy=1 is ignored. Operands and op may change freely after acceptance.
- Latency: start accepted at edge N; RUN occupies edges N+1..N+WIDTH (one iteration per cycle); done=1 and result valid during the cycle after edge N+WIDTH. Total WIDTH+1 cycles start-to-done.
- busy=1 exactly during RUN; busy=0 in the DONE cycle.
- Mul iteration: if multiplier lsb=1, {carry,hi} = hi + multiplicand; then shift {carry,hi,lo} right by 1. Result = lo. Overflow beyond WIDTH bits is discarded.
- Div/mod iteration: rem = {rem[WIDTH-2:0], dividend msb}; shift dividend left. trial = rem - divisor.
  - No borrow: rem=trial, quotient bit=1.
  - Borrow: rem unchanged, quotient bit=0.
- Div by zero (b==0 at accept, op div/mod): skip RUN; go directly to DONE on the next edge with done=1, div_by_zero=1. result=all-ones for div, a for mod. div_by_zero=0 for every other completion.
- The single add/sub path is the only arithmetic resource. It is steered by op and by a MUX on operand selection; no second adder.
- result and div_by_zero update only on entry to DONE.

Optional Feature:
- Macro MULDIV_SIGNED_EN.
- Defined: operands are two's-complement.
  - div/mod run on magnitudes; quotient negated if sign(a)^sign(b); remainder takes sign(a).
  - Negation is applied on entry to DONE; latency unchanged.
  - Mul low bits are sign-agnostic; no correction needed.
  - Special cases: -2^(WIDTH-1) / -1 gives quotient 0x80000000, remainder 0. Div by zero gives quotient all-ones, remainder a.
- Undefined: all operations unsigned; no sign logic synthesized.

Test Plan:
- Reset mid-RUN: start mul 7*6, assert reset at cycle 10 -> busy=0, done never pulses, result=0. A fresh start then completes normally.
- Mul: a=0x0000_1234, b=0x0000_0010 -> done after 33 cycles, result=0x0001_2340, busy high exactly 32 cycles.
- Div/mod back-to-back: div 100/7 -> result=14. Then start asserted in the DONE cycle, mod 100/7 -> result=2 exactly 33 cycles later. No idle cycle between ops.
- Div by zero: div 0x55/0 -> done 1 cycle after start, result=0xFFFF_FFFF, div_by_zero=1. Mod 0x55/0 -> result=0x55.
- Start while busy: second start at cycle 5 of a mul -> ignored; first result unaffected; only one done pulse.
- MULDIV_SIGNED_EN: div -7/2 -> 0xFFFF_FFFD (-3); mod -7/2 -> 0xFFFF_FFFF (-1); div 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000. Without the macro, div 0xFFFF_FFF9/2 -> 0x7FFF_FFFC.

Source files
------------

// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential multiply / divide / modulo unit sharing one adder over WIDTH iterations.
// Define MULDIV_SIGNED_EN for two's-complement div/mod; unsigned otherwise.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t           state_r, state_nxt_s;
    logic [WIDTH-1:0] hi_r, lo_r, opnd_r;   // hi: partial product / remainder, lo: multiplier / quotient
    logic [CW-1:0]    cnt_r;
    logic             is_div_r, is_mod_r;
    logic             accept_s, op_div_s, dbz_s, last_s, cin_s;
    logic [WIDTH:0]   add_a_s, add_b_s;
    logic [WIDTH+1:0] sum_s;
    logic [WIDTH-1:0] hi_it_s, lo_it_s, res_fin_s, a_in_s, b_in_s;

    assign accept_s = start && ((state_r == IDLE) || (state_r == DONE));
    assign op_div_s = (op == 2'b01) || (op == 2'b10);
    assign dbz_s    = op_div_s && (b == {WIDTH{1'b0}});
    assign last_s   = (cnt_r == LAST);

`ifdef MULDIV_SIGNED_EN
    logic neg_q_r, neg_r_r;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return {WIDTH{1'b0}} - v;
    endfunction

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? negate(v) : v;
    endfunction

    // Division runs on magnitudes; signs are reapplied on entry to DONE.
    always_comb begin
        if (op_div_s) begin
            a_in_s = mag(a);
            b_in_s = mag(b);
        end else begin
            a_in_s = a;
            b_in_s = b;
        end
    end

    // Sign-correction flags captured at accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
        end else if (accept_s) begin
            neg_q_r <= op_div_s && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r_r <= op_div_s && a[WIDTH-1];
        end else begin
            neg_q_r <= neg_q_r;
            neg_r_r <= neg_r_r;
        end
    end

    // Final result selection with sign correction.
    always_comb begin
        if (is_mod_r) begin
            res_fin_s = neg_r_r ? negate(hi_it_s) : hi_it_s;
        end else if (is_div_r) begin
            res_fin_s = neg_q_r ? negate(lo_it_s) : lo_it_s;
        end else begin
            res_fin_s = lo_it_s;
        end
    end
`else
    assign a_in_s    = a;
    assign b_in_s    = b;
    assign res_fin_s = is_mod_r ? hi_it_s : lo_it_s;
`endif

    // Shared adder: hi + multiplicand for mul, {rem,next bit} - divisor for div/mod.
    always_comb begin
        if (is_div_r) begin
            add_a_s = {hi_r, lo_r[WIDTH-1]};
            add_b_s = ~{1'b0, opnd_r};
            cin_s   = 1'b1;
        end else begin
            add_a_s = {1'b0, hi_r};
            add_b_s = {1'b0, opnd_r};
            cin_s   = 1'b0;
        end
        sum_s = {1'b0, add_a_s} + {1'b0, add_b_s} + {{(WIDTH + 1){1'b0}}, cin_s};
    end

    // One iteration step; sum_s[WIDTH+1] set means the trial subtraction did not borrow.
    always_comb begin
        if (is_div_r) begin
            if (sum_s[WIDTH+1]) begin
                hi_it_s = sum_s[WIDTH-1:0];
                lo_it_s = {lo_r[WIDTH-2:0], 1'b1};
            end else begin
                hi_it_s = {hi_r[WIDTH-2:0], lo_r[WIDTH-1]};
                lo_it_s = {lo_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (lo_r[0]) begin
                hi_it_s = sum_s[WIDTH:1];
                lo_it_s = {sum_s[0], lo_r[WIDTH-1:1]};
            end else begin
                hi_it_s = {1'b0, hi_r[WIDTH-1:1]};
                lo_it_s = {hi_r[0], lo_r[WIDTH-1:1]};
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = dbz_s ? DONE : RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                if (start) begin
                    state_nxt_s = dbz_s ? DONE : RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Datapath, state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= {WIDTH{1'b0}};
            div_by_zero <= 1'b0;
            hi_r        <= {WIDTH{1'b0}};
            lo_r        <= {WIDTH{1'b0}};
            opnd_r      <= {WIDTH{1'b0}};
            cnt_r       <= {CW{1'b0}};
            is_div_r    <= 1'b0;
            is_mod_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy    <= (state_nxt_s == RUN);
            done    <= (state_nxt_s == DONE);
            if (accept_s) begin
                is_div_r <= op_div_s;
                is_mod_r <= (op == 2'b10);
                hi_r     <= {WIDTH{1'b0}};
                lo_r     <= op_div_s ? a_in_s : b;
                opnd_r   <= op_div_s ? b_in_s : a;
                cnt_r    <= {CW{1'b0}};
                if (dbz_s) begin
                    result      <= (op == 2'b01) ? {WIDTH{1'b1}} : a;
                    div_by_zero <= 1'b1;
                end else begin
                    result      <= result;
                    div_by_zero <= div_by_zero;
                end
            end else if (state_r == RUN) begin
                hi_r  <= hi_it_s;
                lo_r  <= lo_it_s;
                cnt_r <= cnt_r + {{(CW - 1){1'b0}}, 1'b1};
                if (last_s) begin
                    result      <= res_fin_s;
                    div_by_zero <= 1'b0;
                end else begin
                    result      <= result;
                    div_by_zero <= div_by_zero;
                end
            end else begin
                hi_r  <= hi_r;
                lo_r  <= lo_r;
                cnt_r <= cnt_r;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed scenarios plus randomized ops against an arithmetic model.
module tb_muldiv_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [1:0]   op;
    logic [W-1:0] a, b, result;
    logic         busy, done, div_by_zero;
    int           vectors = 0;
    int           miscompares = 0;

    always #5 clk = ~clk;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .div_by_zero(div_by_zero)
    );

    // Reference: {div_by_zero, result} from plain arithmetic.
    function automatic logic [W:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] q, r, p;
        p = x * y;
        if (o != 2'b01 && o != 2'b10) return {1'b0, p};
        if (y == 0) return (o == 2'b01) ? {1'b1, {W{1'b1}}} : {1'b1, x};
`ifdef MULDIV_SIGNED_EN
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'h0;
        end else begin
            q = $signed(x) / $signed(y);
            r = $signed(x) % $signed(y);
        end
`else
        q = x / y;
        r = x % y;
`endif
        return (o == 2'b01) ? {1'b0, q} : {1'b0, r};
    endfunction

    // Issue one op (called right after a negedge) and wait for its done.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic [W-1:0] r, output logic z, output int lat, output int bcnt);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
        lat = 0; bcnt = 0;
        while (lat <= 200) begin
            @(negedge clk);
            if (done) break;
            if (busy) bcnt++;
            lat++;
        end
        r = result; z = div_by_zero;
    endtask

    task automatic test_reset();
        int pulses;
        logic [W-1:0] r; logic z; int lat, bc;
        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy, done, div_by_zero, result} !== {3'b000, 32'h0}) begin
            miscompares++;
            $display("FAIL reset_state got b=%b d=%b z=%b r=%h want 0", busy, done, div_by_zero, result);
        end
        reset = 1'b0;
        @(negedge clk);
        op = 2'b00; a = 32'd7; b = 32'd6; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        vectors++;
        if ({busy, done, result} !== {2'b00, 32'h0}) begin
            miscompares++;
            $display("FAIL reset_mid_run got b=%b d=%b r=%h want 0", busy, done, result);
        end
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) pulses++;
        end
        vectors++;
        if (pulses !== 0) begin
            miscompares++;
            $display("FAIL reset_no_done got %0d done pulses want 0", pulses);
        end
        run_op(2'b00, 32'd7, 32'd6, r, z, lat, bc);
        vectors++;
        if (r !== 32'd42 || lat !== W) begin
            miscompares++;
            $display("FAIL reset_fresh_start got r=%h lat=%0d want 2a lat=%0d", r, lat, W);
        end
    endtask

    task automatic test_mul();
        logic [W-1:0] r; logic z; int lat, bc;
        @(negedge clk);
        run_op(2'b00, 32'h0000_1234, 32'h0000_0010, r, z, lat, bc);
        vectors++;
        if (r !== 32'h0001_2340 || z !== 1'b0) begin
            miscompares++;
            $display("FAIL mul_result got r=%h z=%b want 00012340 0", r, z);
        end
        vectors++;
        if (lat !== W || bc !== W) begin
            miscompares++;
            $display("FAIL mul_timing got lat=%0d busy=%0d want %0d %0d", lat, bc, W, W);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mul_busy_in_done got %b want 0", busy);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || result !== 32'h0001_2340) begin
            miscompares++;
            $display("FAIL mul_done_single_hold got d=%b r=%h want 0 00012340", done, result);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] r; logic z; int lat, bc;
        @(negedge clk);
        run_op(2'b01, 32'd100, 32'd7, r, z, lat, bc);
        vectors++;
        if (r !== 32'd14 || lat !== W) begin
            miscompares++;
            $display("FAIL b2b_div got r=%h lat=%0d want e lat=%0d", r, lat, W);
        end
        run_op(2'b10, 32'd100, 32'd7, r, z, lat, bc);
        vectors++;
        if (r !== 32'd2 || lat !== W || bc !== W) begin
            miscompares++;
            $display("FAIL b2b_mod got r=%h lat=%0d busy=%0d want 2 lat=%0d", r, lat, bc, W);
        end
    endtask

    task automatic test_div_by_zero();
        logic [W-1:0] r; logic z; int lat, bc;
        @(negedge clk);
        run_op(2'b01, 32'h55, 32'h0, r, z, lat, bc);
        vectors++;
        if (r !== 32'hFFFF_FFFF || z !== 1'b1 || lat !== 0) begin
            miscompares++;
            $display("FAIL dbz_div got r=%h z=%b lat=%0d want ffffffff 1 0", r, z, lat);
        end
        @(negedge clk);
        run_op(2'b10, 32'h55, 32'h0, r, z, lat, bc);
        vectors++;
        if (r !== 32'h55 || z !== 1'b1 || lat !== 0) begin
            miscompares++;
            $display("FAIL dbz_mod got r=%h z=%b lat=%0d want 55 1 0", r, z, lat);
        end
        run_op(2'b00, 32'd3, 32'd5, r, z, lat, bc);
        vectors++;
        if (r !== 32'd15 || z !== 1'b0) begin
            miscompares++;
            $display("FAIL dbz_clear got r=%h z=%b want f 0", r, z);
        end
    endtask

    task automatic test_start_while_busy();
        int pulses;
        logic [W-1:0] r;
        @(negedge clk);
        op = 2'b00; a = 32'h111; b = 32'h3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        pulses = 0; r = '0;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                r = result;
            end
            if (k == 4) begin
                op = 2'b01; a = 32'd9; b = 32'd0; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        vectors++;
        if (pulses !== 1 || r !== 32'h333) begin
            miscompares++;
            $display("FAIL start_while_busy got pulses=%0d r=%h want 1 333", pulses, r);
        end
    endtask

    task automatic test_sign_mode();
        logic [W-1:0] r; logic z; int lat, bc;
        @(negedge clk);
`ifdef MULDIV_SIGNED_EN
        run_op(2'b01, 32'hFFFF_FFF9, 32'd2, r, z, lat, bc);
        vectors++;
        if (r !== 32'hFFFF_FFFD) begin
            miscompares++;
            $display("FAIL signed_div got %h want fffffffd", r);
        end
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, r, z, lat, bc);
        vectors++;
        if (r !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL signed_mod got %h want ffffffff", r);
        end
        run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, r, z, lat, bc);
        vectors++;
        if (r !== 32'h8000_0000 || lat !== W) begin
            miscompares++;
            $display("FAIL signed_min_div got r=%h lat=%0d want 80000000", r, lat);
        end
`else
        run_op(2'b01, 32'hFFFF_FFF9, 32'd2, r, z, lat, bc);
        vectors++;
        if (r !== 32'h7FFF_FFFC) begin
            miscompares++;
            $display("FAIL unsigned_div got %h want 7ffffffc", r);
        end
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, r, z, lat, bc);
        vectors++;
        if (r !== 32'h1) begin
            miscompares++;
            $display("FAIL unsigned_mod got %h want 1", r);
        end
`endif
    endtask

    task automatic test_random();
        logic [W-1:0] x, y, r; logic [1:0] o; logic z; int lat, bc, sel;
        logic [W:0] exp_v;
        for (int i = 0; i < 80; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom; y = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) y = '0;
            else if (sel == 1) y = $urandom_range(1, 15);
            else if (sel == 2) x = x >> $urandom_range(0, 31);
            else if (sel == 3) y = y >> $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            exp_v = model(o, x, y);
            run_op(o, x, y, r, z, lat, bc);
            vectors++;
            if ({z, r} !== exp_v || lat !== (exp_v[W] ? 0 : W)) begin
                miscompares++;
                $display("FAIL random op=%0d a=%h b=%h got z=%b r=%h lat=%0d want z=%b r=%h",
                         o, x, y, z, r, lat, exp_v[W], exp_v[W-1:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_back_to_back();
        test_div_by_zero();
        test_start_while_busy();
        test_sign_mode();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
